// File: rtl/udp_rx_pkg.sv
// Shared constants, header field positions and FSM encoding for the UDP
// receive port demultiplexer.
package udp_rx_pkg;

   localparam logic [7:0]  UDP_PROTO    = 8'd17;
   localparam logic [15:0] UDP_HDR_LEN  = 16'd8;
   localparam logic [15:0] MIN_IP_LEN   = UDP_HDR_LEN + 16'd1;
   localparam int          PORT_IDX_W   = 3;

   localparam int SRC_PORT_MSB = 63;
   localparam int SRC_PORT_LSB = 48;
   localparam int DST_PORT_MSB = 47;
   localparam int DST_PORT_LSB = 32;
   localparam int UDP_LEN_MSB  = 31;
   localparam int UDP_LEN_LSB  = 16;
   localparam int CSUM_MSB     = 15;
   localparam int CSUM_LSB     = 0;

   localparam int IP_LEN_MSB   = 55;
   localparam int IP_LEN_LSB   = 40;
   localparam int IP_PROTO_MSB = 36;
   localparam int IP_PROTO_LSB = 29;

   typedef enum logic [1:0] {
      ST_SKIP = 2'd0,
      ST_IDLE = 2'd1,
      ST_FWD  = 2'd2,
      ST_DROP = 2'd3
   } udp_state_e;

endpackage

// File: rtl/udp_port_match.sv
// Destination-port table with runtime configuration and a lowest-index
// priority match evaluated against the currently registered table.
module udp_port_match
   import udp_rx_pkg::*;
#(
   parameter int          P_PORT_NUM     = 4,
   parameter logic [15:0] P_DEFAULT_PORT = 16'h0808
)(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [PORT_IDX_W-1:0] i_cfg_idx,
   input  logic [15:0]           i_cfg_port,
   input  logic                  i_cfg_en,
   input  logic                  i_cfg_valid,
   input  logic [15:0]           i_dst_port,
   output logic                  o_hit,
   output logic [PORT_IDX_W-1:0] o_idx
);

   logic [15:0]           r_port [P_PORT_NUM];
   logic [P_PORT_NUM-1:0] r_en;

   // Writes to indices outside the table never match the loop compare.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < P_PORT_NUM; i++) begin
            r_port[i] <= (i == 0) ? P_DEFAULT_PORT : 16'h0000;
            r_en[i]   <= (i == 0);
         end
      end else begin
         for (int i = 0; i < P_PORT_NUM; i++) begin
            if (i_cfg_valid && (i_cfg_idx == PORT_IDX_W'(i))) begin
               r_port[i] <= i_cfg_port;
               r_en[i]   <= i_cfg_en;
            end
         end
      end
   end

   // Scan from the top down so the lowest matching index is the one kept.
   always_comb begin
      o_hit = 1'b0;
      o_idx = {PORT_IDX_W{1'b0}};
      for (int i = P_PORT_NUM - 1; i >= 0; i--) begin
         o_idx = (r_en[i] && (r_port[i] == i_dst_port)) ? PORT_IDX_W'(i) : o_idx;
         o_hit = (r_en[i] && (r_port[i] == i_dst_port)) | o_hit;
      end
   end

endmodule

// File: rtl/udp_rx_port_demux.sv
// Strips the UDP header from an IP payload stream and forwards the payload of
// packets addressed to an enabled destination port; all others are dropped.
module udp_rx_port_demux
   import udp_rx_pkg::*;
#(
   parameter int          P_PORT_NUM     = 4,
   parameter logic [15:0] P_DEFAULT_PORT = 16'h0808
)(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [2:0]  i_cfg_idx,
   input  logic [15:0] i_cfg_port,
   input  logic        i_cfg_en,
   input  logic        i_cfg_valid,
   input  logic [63:0] s_axis_ip_data,
   input  logic [55:0] s_axis_ip_user,
   input  logic [7:0]  s_axis_ip_keep,
   input  logic        s_axis_ip_last,
   input  logic        s_axis_ip_valid,
   output logic [63:0] m_axis_user_data,
   output logic [31:0] m_axis_user_user,
   output logic [7:0]  m_axis_user_keep,
   output logic        m_axis_user_last,
   output logic        m_axis_user_valid,
   output logic [31:0] o_pkt_cnt,
   output logic [31:0] o_drop_cnt
);

   udp_state_e  r_state;
   udp_state_e  w_next;
   logic [31:0] r_pkt_user;
   logic        w_hit;
   logic [2:0]  w_idx;
   logic        w_qualify;
   logic        w_hdr_beat;
   logic        w_fwd_beat;
   logic        w_pkt_done;
   logic        w_drop_hdr;

   wire [15:0] w_ip_len   = s_axis_ip_user[IP_LEN_MSB:IP_LEN_LSB];
   wire [7:0]  w_ip_proto = s_axis_ip_user[IP_PROTO_MSB:IP_PROTO_LSB];
   wire [15:0] w_dst_port = s_axis_ip_data[DST_PORT_MSB:DST_PORT_LSB];
   wire [15:0] w_udp_len  = s_axis_ip_data[UDP_LEN_MSB:UDP_LEN_LSB];
   wire        w_unused_user = ^{s_axis_ip_user[39:37], s_axis_ip_user[28:0]};

   udp_port_match #(
      .P_PORT_NUM     (P_PORT_NUM),
      .P_DEFAULT_PORT (P_DEFAULT_PORT)
   ) u_match (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_cfg_idx   (i_cfg_idx),
      .i_cfg_port  (i_cfg_port),
      .i_cfg_en    (i_cfg_en),
      .i_cfg_valid (i_cfg_valid),
      .i_dst_port  (w_dst_port),
      .o_hit       (w_hit),
      .o_idx       (w_idx)
   );

   assign w_qualify = (w_ip_proto == UDP_PROTO) && (w_ip_len >= MIN_IP_LEN)
                    && (w_udp_len == w_ip_len) && w_hit;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_SKIP;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_SKIP: begin
            if (!s_axis_ip_valid || s_axis_ip_last) w_next = ST_IDLE;
            else                                    w_next = ST_SKIP;
         end
         ST_IDLE: begin
            if (s_axis_ip_valid && !s_axis_ip_last) w_next = w_qualify ? ST_FWD : ST_DROP;
            else                                    w_next = ST_IDLE;
         end
         ST_FWD, ST_DROP: begin
            if (s_axis_ip_valid && s_axis_ip_last)  w_next = ST_IDLE;
            else                                    w_next = r_state;
         end
         default: w_next = ST_SKIP;
      endcase
   end

   always_comb begin
      w_hdr_beat = 1'b0;
      w_fwd_beat = 1'b0;
      case (r_state)
         ST_IDLE: w_hdr_beat = s_axis_ip_valid;
         ST_FWD:  w_fwd_beat = s_axis_ip_valid;
         default: begin
            w_hdr_beat = 1'b0;
            w_fwd_beat = 1'b0;
         end
      endcase
      w_pkt_done = w_fwd_beat && s_axis_ip_last;
      w_drop_hdr = w_hdr_beat && !w_qualify;
   end

   // Sideband user word is latched on the header and replayed on every beat.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pkt_user        <= 32'd0;
         m_axis_user_data  <= 64'd0;
         m_axis_user_user  <= 32'd0;
         m_axis_user_keep  <= 8'd0;
         m_axis_user_last  <= 1'b0;
         m_axis_user_valid <= 1'b0;
         o_pkt_cnt         <= 32'd0;
         o_drop_cnt        <= 32'd0;
      end else begin
         m_axis_user_valid <= w_fwd_beat;
         m_axis_user_last  <= w_fwd_beat && s_axis_ip_last;
         if (w_fwd_beat) begin
            m_axis_user_data <= s_axis_ip_data;
            m_axis_user_keep <= s_axis_ip_last ? s_axis_ip_keep : 8'hFF;
            m_axis_user_user <= r_pkt_user;
         end
         if (w_hdr_beat) r_pkt_user <= {13'd0, w_idx, w_ip_len - UDP_HDR_LEN};
         if (w_pkt_done) o_pkt_cnt  <= o_pkt_cnt + 32'd1;
         if (w_drop_hdr) o_drop_cnt <= o_drop_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_udp_rx_port_demux.sv
// Directed, table-driven bench for udp_rx_port_demux with hand-written
// sequences for configuration changes and mid-packet reset.
module tb_udp_rx_port_demux;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  cfg_idx;
   logic [15:0] cfg_port;
   logic        cfg_en;
   logic        cfg_valid;
   logic [63:0] in_data;
   logic [55:0] in_user;
   logic [7:0]  in_keep;
   logic        in_last;
   logic        in_valid;
   logic [63:0] out_data;
   logic [31:0] out_user;
   logic [7:0]  out_keep;
   logic        out_last;
   logic        out_valid;
   logic [31:0] pkt_cnt;
   logic [31:0] drop_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] data;
      logic [55:0] user;
      logic [7:0]  keep;
      logic        last;
      logic        valid;
      logic        e_valid;
      logic [7:0]  e_keep;
      logic        e_last;
      logic [31:0] e_user;
      logic [31:0] e_pkt;
      logic [31:0] e_drop;
   } vec_t;

   vec_t tbl[$];

   udp_rx_port_demux #(.P_PORT_NUM(4), .P_DEFAULT_PORT(16'h0808)) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_cfg_idx         (cfg_idx),
      .i_cfg_port        (cfg_port),
      .i_cfg_en          (cfg_en),
      .i_cfg_valid       (cfg_valid),
      .s_axis_ip_data    (in_data),
      .s_axis_ip_user    (in_user),
      .s_axis_ip_keep    (in_keep),
      .s_axis_ip_last    (in_last),
      .s_axis_ip_valid   (in_valid),
      .m_axis_user_data  (out_data),
      .m_axis_user_user  (out_user),
      .m_axis_user_keep  (out_keep),
      .m_axis_user_last  (out_last),
      .m_axis_user_valid (out_valid),
      .o_pkt_cnt         (pkt_cnt),
      .o_drop_cnt        (drop_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [55:0] ipu(input logic [15:0] len, input logic [7:0] proto);
      return {len, 3'd0, proto, 29'd0};
   endfunction

   function automatic logic [63:0] hdr(input logic [15:0] dst, input logic [15:0] ulen);
      return {16'hC000, dst, ulen, 16'hBEEF};
   endfunction

   function automatic vec_t mkv(input logic [63:0] d, input logic [55:0] u, input logic [7:0] k,
                                input logic l, input logic v, input logic ev, input logic [7:0] ek,
                                input logic el, input logic [31:0] eu, input logic [31:0] ep,
                                input logic [31:0] ed);
      vec_t r;
      r.data = d; r.user = u; r.keep = k; r.last = l; r.valid = v;
      r.e_valid = ev; r.e_keep = ek; r.e_last = el; r.e_user = eu; r.e_pkt = ep; r.e_drop = ed;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      in_data  = v.data;
      in_user  = v.user;
      in_keep  = v.keep;
      in_last  = v.last;
      in_valid = v.valid;
      @(posedge clk);
      #1;
      chk({tag, " valid"}, 64'(out_valid), 64'(v.e_valid));
      chk({tag, " pkt_cnt"}, 64'(pkt_cnt), 64'(v.e_pkt));
      chk({tag, " drop_cnt"}, 64'(drop_cnt), 64'(v.e_drop));
      if (v.e_valid) begin
         chk({tag, " data"}, out_data, v.data);
         chk({tag, " keep"}, 64'(out_keep), 64'(v.e_keep));
         chk({tag, " last"}, 64'(out_last), 64'(v.e_last));
         chk({tag, " user"}, 64'(out_user), 64'(v.e_user));
      end
   endtask

   task automatic set_cfg(input logic [2:0] idx, input logic [15:0] port, input logic en);
      cfg_idx = idx; cfg_port = port; cfg_en = en; cfg_valid = 1'b1;
   endtask

   task automatic clr_cfg();
      cfg_valid = 1'b0; cfg_idx = 3'd0; cfg_port = 16'h0000; cfg_en = 1'b0;
   endtask

   localparam logic [63:0] D1 = 64'h0102030405060708;
   localparam logic [63:0] D2 = 64'h1112131415161718;
   localparam logic [63:0] D3 = 64'h2122232425262728;
   localparam logic [63:0] D4 = 64'h3132333435363738;
   localparam logic [55:0] U0 = 56'd0;

   initial begin
      rst = 1'b1;
      clr_cfg();
      in_data = 64'd0; in_user = 56'd0; in_keep = 8'd0; in_last = 1'b0; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset valid", 64'(out_valid), 64'd0);
      chk("reset data", out_data, 64'd0);
      chk("reset user", 64'(out_user), 64'd0);
      chk("reset keep", 64'(out_keep), 64'd0);
      chk("reset last", 64'(out_last), 64'd0);
      chk("reset pkt_cnt", 64'(pkt_cnt), 64'd0);
      chk("reset drop_cnt", 64'(drop_cnt), 64'd0);
      rst = 1'b0;

      // idle beat leaves SKIP
      tbl.push_back(mkv(64'd0, U0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'd0, 32'd0));
      // good 3-beat packet, IP len 20
      tbl.push_back(mkv(hdr(16'h0808, 16'd20), ipu(16'd20, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd0, 32'd0));
      tbl.push_back(mkv(D1, ipu(16'd20, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 32'h0000000C, 32'd0, 32'd0));
      tbl.push_back(mkv(D2, ipu(16'd20, 8'd17), 8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0, 1'b1, 32'h0000000C, 32'd1, 32'd0));
      tbl.push_back(mkv(64'd0, U0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'd1, 32'd0));
      // TCP packet dropped
      tbl.push_back(mkv(hdr(16'h0808, 16'd20), ipu(16'd20, 8'd6), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd1, 32'd1));
      tbl.push_back(mkv(D1, ipu(16'd20, 8'd6), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd1, 32'd1));
      tbl.push_back(mkv(D2, ipu(16'd20, 8'd6), 8'hF0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd1, 32'd1));
      // UDP length 28 vs IP length 20
      tbl.push_back(mkv(hdr(16'h0808, 16'd28), ipu(16'd20, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd1, 32'd2));
      tbl.push_back(mkv(D1, ipu(16'd20, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd1, 32'd2));
      tbl.push_back(mkv(D2, ipu(16'd20, 8'd17), 8'hF0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd1, 32'd2));
      // good packet with an internal gap, back-to-back with the next one
      tbl.push_back(mkv(hdr(16'h0808, 16'd20), ipu(16'd20, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd1, 32'd2));
      tbl.push_back(mkv(D3, ipu(16'd20, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 32'h0000000C, 32'd1, 32'd2));
      tbl.push_back(mkv(64'd0, U0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'd1, 32'd2));
      tbl.push_back(mkv(D4, ipu(16'd20, 8'd17), 8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0, 1'b1, 32'h0000000C, 32'd2, 32'd2));
      tbl.push_back(mkv(hdr(16'h0808, 16'd17), ipu(16'd17, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd2, 32'd2));
      tbl.push_back(mkv(D1, ipu(16'd17, 8'd17), 8'h3C, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 32'h00000009, 32'd2, 32'd2));
      tbl.push_back(mkv(D2, ipu(16'd17, 8'd17), 8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 32'h00000009, 32'd3, 32'd2));
      // header-only packets: disqualified counts as drop, qualified counts nothing
      tbl.push_back(mkv(hdr(16'h9999, 16'd20), ipu(16'd20, 8'd17), 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd3, 32'd3));
      tbl.push_back(mkv(hdr(16'h0808, 16'd20), ipu(16'd20, 8'd17), 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd3, 32'd3));
      // IP length 8 is too short; gap inside dropped packet
      tbl.push_back(mkv(hdr(16'h0808, 16'd8), ipu(16'd8, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd3, 32'd4));
      tbl.push_back(mkv(64'd0, U0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'd3, 32'd4));
      tbl.push_back(mkv(D1, ipu(16'd8, 8'd17), 8'h80, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd3, 32'd4));
      // port 0 matches a disabled entry only
      tbl.push_back(mkv(hdr(16'h0000, 16'd20), ipu(16'd20, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd3, 32'd5));
      tbl.push_back(mkv(D1, ipu(16'd20, 8'd17), 8'hF0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd3, 32'd5));
      // IP length 9 is the shortest accepted
      tbl.push_back(mkv(hdr(16'h0808, 16'd9), ipu(16'd9, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd3, 32'd5));
      tbl.push_back(mkv(D3, ipu(16'd9, 8'd17), 8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 32'h00000001, 32'd4, 32'd5));

      for (int i = 0; i < tbl.size(); i++) begin
         run_vec(tbl[i], $sformatf("vec%0d", i));
      end

      // Two entries share a port: lowest enabled index wins.
      set_cfg(3'd1, 16'h1234, 1'b1);
      run_vec(mkv(64'd0, U0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'd4, 32'd5), "cfg1");
      set_cfg(3'd3, 16'h1234, 1'b1);
      run_vec(mkv(64'd0, U0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'd4, 32'd5), "cfg3");
      set_cfg(3'd5, 16'h5555, 1'b1);
      run_vec(mkv(64'd0, U0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'd4, 32'd5), "cfg5");
      clr_cfg();
      run_vec(mkv(hdr(16'h1234, 16'd16), ipu(16'd16, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd4, 32'd5), "prio hdr");
      run_vec(mkv(D1, ipu(16'd16, 8'd17), 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 32'h00010008, 32'd5, 32'd5), "prio idx1");
      set_cfg(3'd1, 16'h1234, 1'b0);
      run_vec(mkv(64'd0, U0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'd5, 32'd5), "dis1");
      clr_cfg();
      run_vec(mkv(hdr(16'h1234, 16'd16), ipu(16'd16, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd5, 32'd5), "prio hdr2");
      run_vec(mkv(D2, ipu(16'd16, 8'd17), 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 32'h00030008, 32'd6, 32'd5), "prio idx3");
      // out-of-range write had no effect
      run_vec(mkv(hdr(16'h5555, 16'd16), ipu(16'd16, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd6, 32'd6), "oor hdr");
      run_vec(mkv(D1, ipu(16'd16, 8'd17), 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd6, 32'd6), "oor pay");
      // write concurrent with header does not apply to that packet
      set_cfg(3'd2, 16'h7777, 1'b1);
      run_vec(mkv(hdr(16'h7777, 16'd16), ipu(16'd16, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd6, 32'd7), "conc hdr");
      clr_cfg();
      run_vec(mkv(D1, ipu(16'd16, 8'd17), 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd6, 32'd7), "conc pay");
      run_vec(mkv(hdr(16'h7777, 16'd16), ipu(16'd16, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd6, 32'd7), "new hdr");
      run_vec(mkv(D3, ipu(16'd16, 8'd17), 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 32'h00020008, 32'd7, 32'd7), "new idx2");

      // Reset on the second beat of a 5-beat packet.
      run_vec(mkv(hdr(16'h0808, 16'd40), ipu(16'd40, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd7, 32'd7), "rst hdr");
      rst = 1'b1;
      run_vec(mkv(D1, ipu(16'd40, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd0, 32'd0), "rst b1");
      rst = 1'b0;
      run_vec(mkv(D2, ipu(16'd40, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd0, 32'd0), "rst b2");
      run_vec(mkv(D3, ipu(16'd40, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd0, 32'd0), "rst b3");
      run_vec(mkv(D4, ipu(16'd40, 8'd17), 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd0, 32'd0), "rst b4");
      run_vec(mkv(hdr(16'h0808, 16'd20), ipu(16'd20, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd0, 32'd0), "post hdr");
      run_vec(mkv(D1, ipu(16'd20, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 32'h0000000C, 32'd0, 32'd0), "post b1");
      run_vec(mkv(D2, ipu(16'd20, 8'd17), 8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0, 1'b1, 32'h0000000C, 32'd1, 32'd0), "post b2");
      // table restored by reset: 0x1234 no longer matches
      run_vec(mkv(hdr(16'h1234, 16'd16), ipu(16'd16, 8'd17), 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd1, 32'd1), "post tbl hdr");
      run_vec(mkv(D1, ipu(16'd16, 8'd17), 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'd1, 32'd1), "post tbl pay");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
